// File: rtl/om_stream_pkg.sv
// Shared definitions for the output-memory result streamer: default
// widths matching the bellmanford memories, the unreachable distance
// code and the streamer FSM state encoding.
package om_stream_pkg;

    localparam int          ADDR_W_DEF   = 13;
    localparam int          DATA_W_DEF   = 16;
    localparam logic [15:0] INF_CODE_DEF = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        NEG    = 3'd1,
        STREAM = 3'd2,
        FLUSH  = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/om_out_reg.sv
// Output holding register for the result stream.
// Handshake: a word transfers on a rising clock edge where out_valid and
// out_ready are both high; while out_valid is high and out_ready is low the
// register holds every field unchanged and out_valid stays high.
module om_out_reg #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [ADDR_W-1:0] ld_index,
    input  logic              ld_unreach,
    input  logic              ld_neg,
    input  logic              ld_last,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_unreach,
    output logic              out_neg,
    output logic              out_last,
    output logic              can_load,
    output logic              fire
);

    assign fire     = out_valid & out_ready;
    assign can_load = ~out_valid | out_ready;

    // Load a new word when told to; otherwise retire the held word on handshake.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_index   <= '0;
            out_unreach <= 1'b0;
            out_neg     <= 1'b0;
            out_last    <= 1'b0;
        end else if (load) begin
            out_valid   <= ld_valid;
            out_data    <= ld_data;
            out_index   <= ld_index;
            out_unreach <= ld_unreach;
            out_neg     <= ld_neg;
            out_last    <= ld_last;
        end else if (fire) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: rtl/om_result_streamer.sv
// Drains the Bellman-Ford output memory as a valid/ready stream once the
// solver finishes, or emits one negative-cycle marker word instead.
// Optional build macro OMRS_SKIP_UNREACH_EN: drop unreachable (INF_CODE)
// words from the stream instead of tagging them.
module om_result_streamer
    import om_stream_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                DATA_W    = DATA_W_DEF,
    parameter int                NUM_NODES = 8192,
    parameter logic [DATA_W-1:0] INF_CODE  = INF_CODE_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              finish,
    input  logic              neg_cycle,
    output logic [ADDR_W-1:0] OMAR,
    input  logic [DATA_W-1:0] OMDR,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_unreach,
    output logic              out_neg,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   emit_count,
    output logic [2:0]        state_dbg
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_NODES - 1);

    state_t            state, state_nxt;
    logic              finish_q;
    logic              start;
    logic              keep_word;
    logic              load, ld_valid, ld_unreach, ld_neg, ld_last;
    logic [DATA_W-1:0] ld_data;
    logic [ADDR_W-1:0] ld_index;
    logic              omar_clr, omar_inc, busy_set, busy_clr, count_clr;
    logic              can_load, fire;

    assign start     = finish & ~finish_q;
    assign done      = (state == DONE);
    assign state_dbg = state;

`ifdef OMRS_SKIP_UNREACH_EN
    assign keep_word = (OMDR != INF_CODE);
`else
    assign keep_word = 1'b1;
`endif

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and per-cycle control for the sweep.
    always_comb begin
        state_nxt  = state;
        load       = 1'b0;
        ld_valid   = 1'b0;
        ld_data    = OMDR;
        ld_index   = OMAR;
        ld_unreach = (OMDR == INF_CODE);
        ld_neg     = 1'b0;
        ld_last    = (OMAR == LAST_ADDR);
        omar_clr   = 1'b0;
        omar_inc   = 1'b0;
        busy_set   = 1'b0;
        busy_clr   = 1'b0;
        count_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    busy_set  = 1'b1;
                    count_clr = 1'b1;
                    if (neg_cycle) begin
                        state_nxt  = NEG;
                        load       = 1'b1;
                        ld_valid   = 1'b1;
                        ld_data    = '0;
                        ld_index   = '0;
                        ld_unreach = 1'b0;
                        ld_neg     = 1'b1;
                        ld_last    = 1'b1;
                    end else begin
                        state_nxt = STREAM;
                        omar_clr  = 1'b1;
                    end
                end
            end
            NEG: begin
                if (fire) state_nxt = DONE;
            end
            STREAM: begin
                if (can_load) begin
                    load     = 1'b1;
                    ld_valid = keep_word;
                    if (OMAR == LAST_ADDR) state_nxt = FLUSH;
                    else                   omar_inc  = 1'b1;
                end
            end
            FLUSH: begin
                // Either the final word handshakes now, or it was dropped.
                if (can_load) state_nxt = DONE;
            end
            DONE: begin
                busy_clr  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Finish edge detector, read address counter and busy flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            finish_q <= 1'b0;
            OMAR     <= '0;
            busy     <= 1'b0;
        end else begin
            finish_q <= finish;
            if (omar_clr)      OMAR <= '0;
            else if (omar_inc) OMAR <= OMAR + ADDR_W'(1);
            if (busy_set)      busy <= 1'b1;
            else if (busy_clr) busy <= 1'b0;
        end
    end

    // Count words handshaken in the current stream.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)         emit_count <= '0;
        else if (count_clr) emit_count <= '0;
        else if (fire)      emit_count <= emit_count + (ADDR_W + 1)'(1);
    end

    om_out_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clock       (clock),
        .reset       (reset),
        .load        (load),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_index    (ld_index),
        .ld_unreach  (ld_unreach),
        .ld_neg      (ld_neg),
        .ld_last     (ld_last),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_index   (out_index),
        .out_unreach (out_unreach),
        .out_neg     (out_neg),
        .out_last    (out_last),
        .can_load    (can_load),
        .fire        (fire)
    );

endmodule
